gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank.sv | 155 +++++++++++++++
 tb/tb_gpio_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: Wishbone GPIO bank with two-flop input synchroniser, ODR with set/clear
// aliases, and optional edge-detect interrupts compiled in by defining GPIO_BANK_IRQ_EN.
module gpio_bank #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h8000_1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_adr_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    localparam logic [2:0] IDX_IDR  = 3'd0;
    localparam logic [2:0] IDX_ODR  = 3'd1;
    localparam logic [2:0] IDX_DIR  = 3'd2;
    localparam logic [2:0] IDX_SET  = 3'd3;
    localparam logic [2:0] IDX_CLR  = 3'd4;
    localparam logic [2:0] IDX_EN   = 3'd5;
    localparam logic [2:0] IDX_STAT = 3'd6;
    localparam logic [2:0] IDX_EDGE = 3'd7;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r           = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic             req;
    logic [31:0]      offset;
    logic             mapped;
    logic [2:0]       idx;
    logic             wr_en;
    logic [WIDTH-1:0] wdat;
    logic [31:0]      rdata;
    logic             unused_dat;

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] odr;
    logic [WIDTH-1:0] dir;

    // A request is only taken while no ack is outstanding, so strobes are acked every other cycle.
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign offset     = wb_adr_i - BASE_ADDR;
    assign mapped     = (offset[31:5] == 27'd0) && (offset[1:0] == 2'b00);
    assign idx        = offset[4:2];
    assign wr_en      = req & wb_we_i & mapped;
    assign wdat       = wb_dat_i[WIDTH-1:0];
    assign unused_dat = ^wb_dat_i;

    assign gpio_o  = odr;
    assign gpio_oe = dir;

    // Input synchroniser stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gpio_i;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odr <= '0;
            dir <= '0;
        end else if (wr_en) begin
            case (idx)
                IDX_ODR: odr <= wdat;
                IDX_SET: odr <= odr | wdat;
                IDX_CLR: odr <= odr & ~wdat;
                IDX_DIR: dir <= wdat;
                default: ;
            endcase
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_stat;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] prev_p2;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c_mask;

    // Detection compares real sample history, so a polarity change alone never fires.
    assign edge_det = (edge_sel & sync_p1 & ~prev_p2) | (~edge_sel & ~sync_p1 & prev_p2);
    assign w1c_mask = (wr_en && (idx == IDX_STAT)) ? wdat : '0;
    assign irq_o    = |(irq_stat & irq_en);

    // Edge-detect stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_p2  <= '0;
            irq_stat <= '0;
            irq_en   <= '0;
            edge_sel <= '0;
        end else begin
            prev_p2  <= sync_p1;
            irq_stat <= (irq_stat & ~w1c_mask) | edge_det;
            if (wr_en && (idx == IDX_EN)) begin
                irq_en <= wdat;
            end
            if (wr_en && (idx == IDX_EDGE)) begin
                edge_sel <= wdat;
            end
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = 32'hFFFF_FFFF;
        if (mapped) begin
            case (idx)
                IDX_IDR:  rdata = zext(sync_p1);
                IDX_ODR:  rdata = zext(odr);
                IDX_DIR:  rdata = zext(dir);
`ifdef GPIO_BANK_IRQ_EN
                IDX_EN:   rdata = zext(irq_en);
                IDX_STAT: rdata = zext(irq_stat);
                IDX_EDGE: rdata = zext(edge_sel);
`endif
                default:  rdata = 32'h0000_0000;
            endcase
        end
    end

    // Bus response stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0000_0000;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                wb_dat_o <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard bench for gpio_bank; read expectations come from a register-level
// model and are checked by a monitor on each ack. Interrupt checks follow GPIO_BANK_IRQ_EN.
module tb_gpio_bank;

    localparam logic [31:0] BASE = 32'h8000_1000;
    localparam logic [31:0] M    = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_adr_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [15:0] gpio_i = '0;
    logic [15:0] gpio_o;
    logic [15:0] gpio_oe;
    logic        irq_o;

    gpio_bank #(.WIDTH(16), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_i(wb_adr_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  total = 0;
    int  bad   = 0;

    // Register-level reference state
    logic [31:0] m_odr = '0, m_dir = '0, m_en = '0, m_stat = '0, m_edge = '0;
    logic [15:0] m_pins = '0;

    always @(negedge clk) begin
        if (wb_ack_o) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: ack seen with no transaction outstanding");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.rd) begin
                    total++;
                    if (wb_dat_o !== mon_e.exp) begin
                        bad++;
                        $display("FAIL %s: got %h expected %h", mon_e.name, wb_dat_o, mon_e.exp);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] off);
        case (off)
            32'h00: return {16'h0, m_pins};
            32'h04: return m_odr;
            32'h08: return m_dir;
            32'h0C, 32'h10: return 32'h0;
`ifdef GPIO_BANK_IRQ_EN
            32'h14: return m_en;
            32'h18: return m_stat;
            32'h1C: return m_edge;
`else
            32'h14, 32'h18, 32'h1C: return 32'h0;
`endif
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_wr(input logic [31:0] off, input logic [31:0] d);
        case (off)
            32'h04: m_odr = d & M;
            32'h08: m_dir = d & M;
            32'h0C: m_odr = m_odr | (d & M);
            32'h10: m_odr = m_odr & ~d & M;
`ifdef GPIO_BANK_IRQ_EN
            32'h14: m_en = d & M;
            32'h18: m_stat = m_stat & ~d;
            32'h1C: m_edge = d & M;
`endif
            default: ;
        endcase
    endtask

    task automatic wb_xfer(input bit we, input logic [31:0] off, input logic [31:0] d,
                           input logic [31:0] exp, input string name);
        sb_t e;
        bit  got;
        e.rd = !we; e.exp = exp; e.name = name;
        sb.push_back(e);
        wb_adr_i = BASE + off; wb_dat_i = d; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            got = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout_%s: got no ack expected ack", name);
            void'(sb.pop_back());
        end
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
        model_wr(off, d);
        wb_xfer(1'b1, off, d, 32'h0, "wr");
    endtask

    task automatic wb_read(input logic [31:0] off, input string name);
        wb_xfer(1'b0, off, 32'h0, model_rd(off), name);
    endtask

    task automatic set_pins(input logic [15:0] v);
        logic [15:0] rise, fall;
        rise   = v & ~m_pins;
        fall   = ~v & m_pins;
        gpio_i = v;
        m_stat = m_stat | {16'h0, (rise & m_edge[15:0]) | (fall & ~m_edge[15:0])};
        m_pins = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic exp_irq();
`ifdef GPIO_BANK_IRQ_EN
        return |(m_stat & m_en);
`else
        return 1'b0;
`endif
    endfunction

    logic [31:0] offs[10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                              32'h14, 32'h18, 32'h1C, 32'h20, 32'h40};

    initial begin
        // Reset state
        #3;
        check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_gpio_o", {16'h0, gpio_o}, 32'h0);
        check("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ODR write / read / output
        wb_write(32'h04, 32'h0000_A5A5);
        check("gpio_o_at_ack", {16'h0, gpio_o}, 32'h0000_A5A5);
        @(posedge clk); #1;
        check("gpio_o_next", {16'h0, gpio_o}, 32'h0000_A5A5);
        wb_read(32'h04, "odr_a5a5");

        // SET / CLR
        wb_write(32'h04, 32'h0000_00F0);
        wb_write(32'h0C, 32'h0000_000F);
        wb_write(32'h10, 32'h0000_0030);
        wb_read(32'h04, "odr_setclr");
        wb_read(32'h0C, "set_rd0");
        wb_read(32'h10, "clr_rd0");
        check("gpio_o_setclr", {16'h0, gpio_o}, 32'h0000_00CF);

        // Synchroniser latency and unmapped read
        gpio_i = 16'h0001;
        @(posedge clk); #1;
        wb_xfer(1'b0, 32'h00, 32'h0, 32'h0, "idr_early");
        m_pins = 16'h0001;
        wb_read(32'h00, "idr_late");
        wb_read(32'h40, "unmapped");
        wb_write(32'h40, 32'h1234_5678);
        set_pins(16'h0000);

`ifdef GPIO_BANK_IRQ_EN
        wb_write(32'h14, 32'h1);
        wb_write(32'h1C, 32'h1);
        gpio_i = 16'h0001; m_pins = 16'h0001; m_stat = m_stat | 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("irq_not_yet", {31'h0, irq_o}, 32'h0);
        @(posedge clk); #1;
        check("irq_rise", {31'h0, irq_o}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        set_pins(16'h0000);
        wb_read(32'h18, "stat_set");
        check("irq_high", {31'h0, irq_o}, 32'h1);
        wb_write(32'h18, 32'h1);
        check("irq_cleared", {31'h0, irq_o}, 32'h0);
        wb_read(32'h18, "stat_clr");
        gpio_i = 16'h0001; m_pins = 16'h0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_write(32'h18, 32'h1);
        m_stat = m_stat | 32'h1;
        wb_read(32'h18, "stat_w1c_race");
        set_pins(16'h0000);
`else
        wb_write(32'h14, 32'hFFFF);
        wb_write(32'h18, 32'hFFFF);
        wb_write(32'h1C, 32'hFFFF);
        set_pins(16'h00FF);
        set_pins(16'h0000);
        check("irq_off", {31'h0, irq_o}, 32'h0);
        wb_read(32'h18, "stat_off");
        wb_read(32'h1C, "edge_off");
`endif

        // Randomised register and pin traffic
        for (int it = 0; it < 80; it++) begin
            int op;
            logic [31:0] off, d;
            op  = $urandom_range(0, 9);
            off = offs[$urandom_range(0, 9)];
            d   = $urandom;
            if (op < 2) begin
                set_pins(16'($urandom));
            end else if (op < 6) begin
                wb_write(off, d);
                check("rnd_gpio_o", {16'h0, gpio_o}, m_odr);
                check("rnd_gpio_oe", {16'h0, gpio_oe}, m_dir);
            end else begin
                wb_read(off, "rnd_read");
            end
            check("rnd_irq", {31'h0, irq_o}, {31'h0, exp_irq()});
        end

        // Reset during a strobed DIR write
        set_pins(16'h0000);
        wb_write(32'h08, 32'h0000_1234);
        @(posedge clk); #1;
        wb_adr_i = BASE + 32'h08; wb_dat_i = 32'h0000_FFFF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("rst_mid_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_mid_oe", {16'h0, gpio_oe}, 32'h0);
        check("rst_mid_irq", {31'h0, irq_o}, 32'h0);
        m_odr = '0; m_dir = '0; m_en = '0; m_stat = '0; m_edge = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        wb_read(32'h08, "dir_after_rst");
        check("oe_after_rst", {16'h0, gpio_oe}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
